// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling default and divider helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HI
    } state_t;

    localparam int OVERSAMPLE_DEF = 16;

    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        return clk_freq / (baud * os);
    endfunction

    function automatic logic majority3(input logic [2:0] v);
        return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Divides clk by DIV into a one-cycle tick; clear restarts the phase at zero.
// Latency: tick DIV cycles after clear; no backpressure.
module baud_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver with 3-sample mid-bit vote and a one-entry holding register.
// Latency: data_valid rises at the mid-stop-bit sample; a full register drops new bytes (overrun).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd_ack,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int OSW = $clog2(OVERSAMPLE);

    if (DIV < 1 || OVERSAMPLE < 16) begin : g_param_check
        $error("uart_rx: need DIV >= 1 and OVERSAMPLE >= 16");
    end

    logic [1:0]     sync;
    logic           rx_s;
    logic           rx_prev;
    state_t         state;
    logic [OSW-1:0] os_cnt;
    logic [2:0]     bit_idx;
    logic [1:0]     vote;
    logic [7:0]     shift_reg;
    logic           tick;
    logic           fall;
    logic           mid;
    logic           last;
    logic           bit_val;
    logic           deliver;

    assign rx_s    = sync[1];
    assign fall    = rx_prev & ~rx_s;
    assign mid     = tick && (os_cnt == OSW'(9));
    assign last    = tick && (os_cnt == OSW'(OVERSAMPLE - 1));
    // Samples from os_cnt 7 and 8 are held in vote; the os_cnt 9 sample is rx_s itself.
    assign bit_val = majority3({vote, rx_s});
    assign deliver = (state == STOP) && mid && bit_val;
    assign busy    = (state != IDLE);

    baud_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear ((state == IDLE) && fall),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sync       <= 2'b11;
            rx_prev    <= 1'b0;
            state      <= IDLE;
            os_cnt     <= '0;
            bit_idx    <= '0;
            vote       <= '0;
            shift_reg  <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sync      <= {sync[0], rx};
            rx_prev   <= rx_s;
            frame_err <= 1'b0;

            if (tick && os_cnt >= OSW'(7) && os_cnt <= OSW'(9)) begin
                vote <= {vote[0], rx_s};
            end
            if (tick) begin
                os_cnt <= last ? '0 : os_cnt + OSW'(1);
            end

            case (state)
                IDLE: begin
                    if (fall) begin
                        state  <= START;
                        os_cnt <= '0;
                    end
                end
                START: begin
                    if (mid && bit_val) begin
                        state <= IDLE;
                    end else if (last) begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (mid) begin
                        shift_reg <= {bit_val, shift_reg[7:1]};
                    end
                    if (last) begin
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (mid) begin
                        if (bit_val) begin
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HI;
                        end
                    end
                end
                WAIT_HI: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // An ack on the delivery cycle frees the slot, so the new byte is taken, not dropped.
            if (deliver && (!data_valid || rd_ack)) begin
                data       <= shift_reg;
                data_valid <= 1'b1;
                if (rd_ack) begin
                    overrun <= 1'b0;
                end
            end else if (deliver) begin
                overrun <= 1'b1;
            end else if (rd_ack && data_valid) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: directed corner frames plus randomized 8N1 traffic.
module tb_uart_rx;

    localparam int BIT_CLK = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rd_ack;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         ferr_cnt = 0;
    int         exp_ferr = 0;
    logic [7:0] exp_q[$];

    uart_rx #(
        .CLK_FREQ   (3_200_000),
        .BAUD       (100_000),
        .OVERSAMPLE (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rd_ack     (rd_ack),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Starts one clk after the next rising edge; leaves rx at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        logic [9:0] bits;
        bits = {stop_ok, b, 1'b0};
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            clks(BIT_CLK);
        end
    endtask

    task automatic ack;
        @(posedge clk);
        #1 rd_ack = 1'b1;
        @(posedge clk);
        #1 rd_ack = 1'b0;
    endtask

    // Monitor: every new byte presented on data is matched against the scoreboard.
    initial begin
        logic       prev_v;
        logic [7:0] prev_d;
        logic [7:0] e;
        prev_v = 1'b0;
        prev_d = 8'h00;
        forever begin
            @(negedge clk);
            if (frame_err === 1'b1) ferr_cnt++;
            if (data_valid === 1'b1 && (!prev_v || data !== prev_d)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h, expected none", data);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_byte", {24'h0, data}, {24'h0, e});
                end
            end
            prev_v = data_valid;
            prev_d = data;
        end
    end

    initial begin
        int         busy_cycles;
        int         f0;
        logic [7:0] b;
        logic       ok;
        logic [7:0] partial;

        reset  = 1'b1;
        rx     = 1'b1;
        rd_ack = 1'b0;
        clks(3);
        check("reset_data", {24'h0, data}, 32'h0);
        check("reset_outputs", {28'h0, data_valid, frame_err, overrun, busy}, 32'h0);
        reset = 1'b0;
        clks(10);

        // 1: single good frame, held without ack
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        check("t1_busy_idle", {31'h0, busy}, 32'h0);
        clks(100);
        check("t1_held_valid", {31'h0, data_valid}, 32'h1);
        check("t1_held_data", {24'h0, data}, 32'hA5);
        check("t1_no_ferr", ferr_cnt, exp_ferr);
        ack();
        clks(2);
        check("t1_ack_clears", {31'h0, data_valid}, 32'h0);

        // 2: short low glitch is rejected, then a real frame
        busy_cycles = 0;
        @(posedge clk);
        #1 rx = 1'b0;
        clks(8);
        rx = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
        end
        check("t2_busy_window", {31'h0, (busy_cycles > 0 && busy_cycles <= 20)}, 32'h1);
        check("t2_no_valid", {31'h0, data_valid}, 32'h0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        clks(5);
        ack();
        clks(5);

        // 3: bad stop bit followed by a held-low line
        f0 = ferr_cnt;
        exp_ferr++;
        send_frame(8'h3C, 1'b0);
        clks(3 * BIT_CLK);
        check("t3_busy_low", {31'h0, busy}, 32'h1);
        check("t3_no_valid", {31'h0, data_valid}, 32'h0);
        rx = 1'b1;
        clks(10);
        check("t3_one_ferr", ferr_cnt - f0, 32'd1);
        check("t3_busy_released", {31'h0, busy}, 32'h0);
        clks(2 * BIT_CLK);

        // 4: back-to-back without ack -> overrun
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        clks(5);
        check("t4_data_kept", {24'h0, data}, 32'h11);
        check("t4_overrun", {31'h0, overrun}, 32'h1);
        ack();
        clks(2);
        check("t4_ack_valid", {31'h0, data_valid}, 32'h0);
        check("t4_ack_overrun", {31'h0, overrun}, 32'h0);
        clks(BIT_CLK);

        // 5: ack coincides exactly with the second delivery
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        clks(20);
        exp_q.push_back(8'h22);
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (311) @(posedge clk);
                #1 rd_ack = 1'b1;
                @(posedge clk);
                #1 rd_ack = 1'b0;
            end
        join
        clks(3);
        check("t5_data", {24'h0, data}, 32'h22);
        check("t5_valid", {31'h0, data_valid}, 32'h1);
        check("t5_no_overrun", {31'h0, overrun}, 32'h0);
        ack();
        clks(BIT_CLK);

        // 6: reset mid-frame after data bit 3
        partial = 8'h77;
        @(posedge clk);
        #1 rx = 1'b0;
        clks(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rx = partial[i];
            clks(BIT_CLK);
        end
        reset = 1'b1;
        rx    = 1'b1;
        clks(1);
        reset = 1'b0;
        check("t6_reset_outputs", {24'h0, data, data_valid, frame_err, overrun, busy}, 32'h0);
        clks(2 * BIT_CLK);
        check("t6_no_delivery", {31'h0, data_valid}, 32'h0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        clks(3);
        check("t6_next_frame", {24'h0, data}, 32'h5A);
        ack();
        clks(BIT_CLK);

        // Randomized traffic: random bytes, stop validity, ack delay and idle gaps
        for (int n = 0; n < 12; n++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            if (ok) exp_q.push_back(b);
            else exp_ferr++;
            send_frame(b, ok);
            if (ok) begin
                clks($urandom_range(0, 20));
                ack();
            end else begin
                rx = 1'b1;
                clks(2 * BIT_CLK);
            end
            clks($urandom_range(0, 30));
        end

        clks(2 * BIT_CLK);
        check("all_bytes_seen", exp_q.size(), 32'd0);
        check("frame_err_total", ferr_cnt, exp_ferr);
        check("final_overrun", {31'h0, overrun}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
